// File: rtl/rank_dequeue_arbiter_if.sv
// Bus between the rank store's push/pop side, the dequeue arbiter and the
// downstream PIFO insertion logic.
interface rank_dequeue_arbiter_if #(
  parameter int FLOWS = 10
);
  logic             enq_valid;
  logic [FLOWS-1:0] enq_flow;
  logic [FLOWS-1:0] flow_full;
  logic             drop;
  logic             pop;
  logic [FLOWS-1:0] pop_flow;
  logic [31:0]      pop_value;
  logic             pop_valid;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_rank;
  logic [FLOWS-1:0] out_flow;
  logic             proto_err;

  modport slave (
    input  enq_valid, enq_flow, pop_value, pop_valid, out_ready,
    output flow_full, drop, pop, pop_flow, out_valid, out_rank, out_flow, proto_err
  );

  modport master (
    output enq_valid, enq_flow, pop_value, pop_valid, out_ready,
    input  flow_full, drop, pop, pop_flow, out_valid, out_rank, out_flow, proto_err
  );
endinterface

// File: rtl/rank_dequeue_arbiter.sv
// Read-side controller for the per-flow rank store: shadows occupancy, picks a
// non-empty flow round-robin, pops it and presents the rank on valid/ready.
module rank_dequeue_arbiter #(
  parameter int FLOWS = 10,
  parameter int SIZE  = 50,
  parameter int CW    = $clog2(SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rank_dequeue_arbiter_if.slave bus,
  output logic [1:0]            dbg_state,
  output logic [FLOWS*CW-1:0]   dbg_cnt
);

  // Output handshake: an entry transfers on a rising clk edge where
  // out_valid && out_ready; once out_valid rises, out_rank/out_flow hold
  // until that transfer, and out_valid never drops without it.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q [FLOWS];
  logic [FLOWS-1:0] full, eligible, inc, dec, grant;
  logic [FLOWS-1:0] last_q, last_d;
  logic             pop_q, pop_d;
  logic [FLOWS-1:0] pop_flow_q, pop_flow_d;
  logic [FLOWS-1:0] out_flow_q, out_flow_d;
  logic [31:0]      out_rank_q, out_rank_d;
  logic             out_valid_q, out_valid_d;
  logic             proto_err_q, proto_err_d;
  logic             drop_q, drop_d;

  // Fullness ignores the same-cycle ISSUE decrement, so a push racing a pop
  // on a full flow is dropped rather than counted.
  always_comb begin
    full     = '0;
    eligible = '0;
    inc      = '0;
    dec      = '0;
    for (int i = 0; i < FLOWS; i++) begin
      full[i]     = (cnt_q[i] == SIZE_C);
      eligible[i] = (cnt_q[i] != '0);
      inc[i]      = bus.enq_valid && bus.enq_flow[i] && !full[i];
      dec[i]      = (state_q == ISSUE) && pop_flow_q[i];
    end
    drop_d = bus.enq_valid && |(bus.enq_flow & full);
  end

  // Round-robin search starting just after the last granted flow.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= FLOWS; k++) begin
      for (int i = 0; i < FLOWS; i++) begin
        if (!found && last_q[i] && eligible[(i + k) % FLOWS]) begin
          grant[(i + k) % FLOWS] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLOWS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < FLOWS; i++) begin
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + ONE_C;
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= {1'b1, {(FLOWS-1){1'b0}}};
      pop_q       <= 1'b0;
      pop_flow_q  <= '0;
      out_flow_q  <= '0;
      out_rank_q  <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      pop_q       <= pop_d;
      pop_flow_q  <= pop_flow_d;
      out_flow_q  <= out_flow_d;
      out_rank_q  <= out_rank_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    pop_d       = pop_q;
    pop_flow_d  = pop_flow_q;
    out_flow_d  = out_flow_q;
    out_rank_d  = out_rank_q;
    out_valid_d = out_valid_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          pop_d      = 1'b1;
          pop_flow_d = grant;
          out_flow_d = grant;
          last_d     = grant;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        pop_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // A missing response loses the entry; the counter was already charged.
        if (bus.pop_valid) begin
          out_rank_d  = bus.pop_value;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.flow_full = full;
  assign bus.drop      = drop_q;
  assign bus.pop       = pop_q;
  assign bus.pop_flow  = pop_flow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rank  = out_rank_q;
  assign bus.out_flow  = out_flow_q;
  assign bus.proto_err = proto_err_q;
  assign dbg_state     = state_q;

  always_comb begin
    dbg_cnt = '0;
    for (int i = 0; i < FLOWS; i++) dbg_cnt[i*CW +: CW] = cnt_q[i];
  end

endmodule

// File: doc/rank_dequeue_arbiter.md
# rank_dequeue_arbiter

Read-side controller for the per-flow rank store. Mirrors every push into the store with per-flow occupancy counters. When the downstream slot is free, it picks a non-empty flow by round-robin and issues a one-hot pop to the store. It captures the returned rank and presents it, tagged with its flow, on a valid/ready output. It sits between the rank store's pop port and the PIFO insertion logic.

## Interface
- `FLOWS`, default 10, number of flows; must match the rank store.
- `SIZE`, default 50, per-flow capacity; must match the rank store.
- `CW`, default `$clog2(SIZE+1)`, counter width.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enq_valid`  in  1  a push is presented to the rank store this cycle
- `enq_flow`  in  FLOWS  one-hot flow of that push
- `flow_full`  out  FLOWS  bit i = flow i holds SIZE ranks; the upstream must not push to it
- `drop`  out  1  one-cycle pulse: the push was to a full flow and was not counted
- `pop`  out  1  pop request to the rank store (registered)
- `pop_flow`  out  FLOWS  one-hot flow for `pop` (registered)
- `pop_value`  in  32  rank returned by the store
- `pop_valid`  in  1  `pop_value` is valid (one cycle after `pop` is sampled)
- `out_valid`  out  1  `out_rank` / `out_flow` hold a dequeued entry
- `out_ready`  in  1  downstream accepts the entry
- `out_rank`  out  32  dequeued rank
- `out_flow`  out  FLOWS  one-hot flow of `out_rank`
- `proto_err`  out  1  sticky: `pop_valid` was missing in WAIT

## Operation
- Per-flow counter `cnt[i]`, width CW, reset 0.
  - +1 when `enq_valid && enq_flow[i] && cnt[i] != SIZE`.
  - −1 when a pop to flow i is sampled (the ISSUE cycle).
  - Both in the same cycle: counter unchanged.
  - `flow_full[i] = (cnt[i] == SIZE)`. The ISSUE decrement is not considered, so a simultaneous push to a full flow in ISSUE is dropped.
- `drop` is registered. It pulses the cycle after a push to a full flow.
- Eligible set: `cnt[i] != 0`.
- Round-robin pointer `last`, one-hot, reset to bit FLOWS-1, so the first grant searches from flow 0.
  - Search order: `last+1 … last+FLOWS`, mod FLOWS.
  - `last` updates to the granted flow on IDLE→ISSUE.
- FSM states, all reset to IDLE:
  - **IDLE**: if any flow is eligible, register `pop<=1`, `pop_flow<=grant`, `out_flow<=grant`, and go to ISSUE. Otherwise stay.
  - **ISSUE**: `pop=1` is visible this cycle. Decrement the counter. Register `pop<=0`. Go to WAIT.
  - **WAIT**: expect `pop_valid=1`.
    - Capture `out_rank<=pop_value` and `out_valid<=1`. Go to HOLD.
    - If `pop_valid=0`, set `proto_err`, leave `out_valid` at 0, and go to IDLE. The entry is lost and the counter is not restored.
  - **HOLD**: while `out_valid && out_ready`, clear `out_valid` and go to IDLE. `out_rank` and `out_flow` stay stable while `out_valid=1 && !out_ready`.
- `pop_valid` outside WAIT is ignored.

## Timing
- Values after reset (async assert, sync-safe deassert): `pop=0`, `pop_flow=0`, `out_valid=0`, `out_rank=0`, `out_flow=0`, `drop=0`, `proto_err=0`, all `cnt=0`, `flow_full=0`.
- Reset asserted mid-operation returns everything to these values at once. Any in-flight pop is abandoned.
- Push at cycle t: the counter increments at the end of t. The flow is eligible in IDLE at t+1.
- Latency from IDLE with an eligible flow to `out_valid=1`: 3 cycles (IDLE, ISSUE, WAIT; `out_valid` rises at the start of the following cycle).
- Peak throughput is one entry per 4 cycles when `out_ready=1` throughout.
- At most one pop is outstanding. `pop` is high for exactly one cycle per grant.
- Counter wrap cannot occur: increments are blocked at SIZE, and decrements only happen for eligible flows.

## Test plan
- **Single entry.** Reset. Push rank 0x2A to flow 3. Hold `out_ready=1` and model the store with 1-cycle `pop_valid`.
  - Required: `pop` high for 1 cycle with `pop_flow=0b0000001000`.
  - Required: `out_valid` 3 cycles after IDLE, with `out_rank=0x2A` and `out_flow=bit 3`.
  - Required: `cnt[3]` returns to 0.
- **Round-robin.** Push 2 ranks each to flows 1, 4 and 7.
  - Required: grant order 1, 4, 7, 1, 4, 7.
  - Required: the first grant after reset searches from flow 0.
- **Backpressure.** Hold `out_ready=0` for 10 cycles with entries pending.
  - Required: `out_rank` stable.
  - Required: no further `pop` until acceptance; the next `pop` is issued one cycle after the handshake.
- **Full / drop.** With SIZE=4, push 5 ranks to flow 0.
  - Required: `flow_full[0]=1` after the 4th push.
  - Required: `drop` pulses once, and `cnt[0]` stays 4.
- **Simultaneous push and pop.** Flow 2 has `cnt=1`. Push to flow 2 during ISSUE of flow 2.
  - Required: `cnt[2]=1` afterwards, and a second grant to flow 2 follows.
- **Protocol error and reset.**
  - Suppress `pop_valid` in WAIT. Required: `proto_err=1` (sticky), `out_valid=0`, FSM back in IDLE.
  - Then assert `rst_n=0` mid-HOLD. Required: all outputs go to 0 immediately.
